// File: rtl/turn_controller.sv
// Chess clock turn sequencer: owns whose timer runs, pause/resume, flag fall
// and the completed-move count. Every output is a flop; nothing is combinational from inputs.
module turn_controller #(
  parameter int MOVE_W = 8
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              BTN1,
  input  logic              BTN2,
  input  logic              START_PAUSE,
  input  logic              FLAG1,
  input  logic              FLAG2,
  output logic              Enable_p1,
  output logic              Enable_p2,
  output logic              INC_p1,
  output logic              INC_p2,
  output logic [MOVE_W-1:0] MOVES,
  output logic              GAME_OVER,
  output logic              LOSER,
  output logic [2:0]        STATE
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN_P1 = 3'd1,
    RUN_P2 = 3'd2,
    PAUSED = 3'd3,
    OVER   = 3'd4
  } state_t;

  state_t state;
  logic   saved;

  assign STATE = state;

  // NOTE: every register in this block uses <= so all branches see the pre-edge values.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state     <= IDLE;
      saved     <= 1'b0;
      Enable_p1 <= 1'b0;
      Enable_p2 <= 1'b0;
      INC_p1    <= 1'b0;
      INC_p2    <= 1'b0;
      MOVES     <= '0;
      GAME_OVER <= 1'b0;
      LOSER     <= 1'b0;
    end else begin
      INC_p1 <= 1'b0;
      INC_p2 <= 1'b0;
      case (state)
        IDLE: begin
          if (START_PAUSE) begin
            state     <= RUN_P1;
            Enable_p1 <= 1'b1;
          end
        end
        RUN_P1: begin
          if (FLAG1) begin
            state     <= OVER;
            Enable_p1 <= 1'b0;
            GAME_OVER <= 1'b1;
            LOSER     <= 1'b0;
          end else if (START_PAUSE) begin
            state     <= PAUSED;
            Enable_p1 <= 1'b0;
            saved     <= 1'b0;
          end else if (BTN1) begin
            state     <= RUN_P2;
            Enable_p1 <= 1'b0;
            Enable_p2 <= 1'b1;
            INC_p1    <= 1'b1;
          end
        end
        RUN_P2: begin
          if (FLAG2) begin
            state     <= OVER;
            Enable_p2 <= 1'b0;
            GAME_OVER <= 1'b1;
            LOSER     <= 1'b1;
          end else if (START_PAUSE) begin
            state     <= PAUSED;
            Enable_p2 <= 1'b0;
            saved     <= 1'b1;
          end else if (BTN2) begin
            state     <= RUN_P1;
            Enable_p2 <= 1'b0;
            Enable_p1 <= 1'b1;
            INC_p2    <= 1'b1;
            // A full move completes when player 2 hands back; the count sticks at all-ones.
            if (MOVES != {MOVE_W{1'b1}}) MOVES <= MOVES + 1'b1;
          end
        end
        PAUSED: begin
          if (START_PAUSE) begin
            if (saved) begin
              state     <= RUN_P2;
              Enable_p2 <= 1'b1;
            end else begin
              state     <= RUN_P1;
              Enable_p1 <= 1'b1;
            end
          end
        end
        OVER: begin
        end
        default: begin
          state     <= IDLE;
          Enable_p1 <= 1'b0;
          Enable_p2 <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller; a second instance with MOVE_W=2 shares
// the stimulus so move-count saturation is observable.
module tb_turn_controller;

  typedef logic [16:0] vec_t;  // {STATE, en1, en2, inc1, inc2, game_over, loser, MOVES[7:0]}

  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] B1   = 5'b10000;
  localparam logic [4:0] B2   = 5'b01000;
  localparam logic [4:0] SP   = 5'b00100;
  localparam logic [4:0] F1   = 5'b00010;
  localparam logic [4:0] F2   = 5'b00001;

  logic       CLK = 1'b0;
  logic       CLR = 1'b1;
  logic       BTN1 = 1'b0, BTN2 = 1'b0, START_PAUSE = 1'b0, FLAG1 = 1'b0, FLAG2 = 1'b0;
  logic       Enable_p1, Enable_p2, INC_p1, INC_p2, GAME_OVER, LOSER;
  logic [7:0] MOVES;
  logic [2:0] STATE;
  logic       s_en1, s_en2, s_inc1, s_inc2, s_go, s_lo;
  logic [1:0] s_moves;
  logic [2:0] s_state;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  turn_controller #(.MOVE_W(8)) u_dut (
    .CLK(CLK), .CLR(CLR), .BTN1(BTN1), .BTN2(BTN2), .START_PAUSE(START_PAUSE),
    .FLAG1(FLAG1), .FLAG2(FLAG2), .Enable_p1(Enable_p1), .Enable_p2(Enable_p2),
    .INC_p1(INC_p1), .INC_p2(INC_p2), .MOVES(MOVES), .GAME_OVER(GAME_OVER),
    .LOSER(LOSER), .STATE(STATE)
  );

  turn_controller #(.MOVE_W(2)) u_small (
    .CLK(CLK), .CLR(CLR), .BTN1(BTN1), .BTN2(BTN2), .START_PAUSE(START_PAUSE),
    .FLAG1(FLAG1), .FLAG2(FLAG2), .Enable_p1(s_en1), .Enable_p2(s_en2),
    .INC_p1(s_inc1), .INC_p2(s_inc2), .MOVES(s_moves), .GAME_OVER(s_go),
    .LOSER(s_lo), .STATE(s_state)
  );

  function automatic vec_t ex(int st, bit e1, bit e2, bit i1, bit i2, bit go, bit lo, int mv);
    return {st[2:0], e1, e2, i1, i2, go, lo, mv[7:0]};
  endfunction

  function automatic vec_t obs();
    return {STATE, Enable_p1, Enable_p2, INC_p1, INC_p2, GAME_OVER, LOSER, MOVES};
  endfunction

  // Drive one cycle of inputs ({BTN1,BTN2,START_PAUSE,FLAG1,FLAG2}) and sample 1ns after the edge.
  task automatic step(input logic [4:0] s);
    @(negedge CLK);
    {BTN1, BTN2, START_PAUSE, FLAG1, FLAG2} = s;
    @(posedge CLK);
    #1;
    {BTN1, BTN2, START_PAUSE, FLAG1, FLAG2} = NONE;
  endtask

  task automatic pulse_clr();
    @(negedge CLK);
    CLR = 1'b1;
    #2;
    CLR = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] stim [4];
    #13;
    vectors++;
    if (obs() !== ex(0, 0, 0, 0, 0, 0, 0, 0)) begin
      miscompares++;
      $display("FAIL reset_values: got %h expected %h", obs(), ex(0, 0, 0, 0, 0, 0, 0, 0));
    end
    CLR = 1'b0;
    stim = '{B1, B2, F1, F2};
    for (int i = 0; i < 4; i++) begin
      step(stim[i]);
      vectors++;
      if (obs() !== ex(0, 0, 0, 0, 0, 0, 0, 0)) begin
        miscompares++;
        $display("FAIL idle_ignore[%0d]: got %h expected %h", i, obs(), ex(0, 0, 0, 0, 0, 0, 0, 0));
      end
    end
  endtask

  task automatic test_handover();
    logic [4:0] stim [5];
    vec_t       exp  [5];
    stim = '{SP, B1, NONE, B2, NONE};
    exp  = '{ex(1, 1, 0, 0, 0, 0, 0, 0), ex(2, 0, 1, 1, 0, 0, 0, 0), ex(2, 0, 1, 0, 0, 0, 0, 0),
             ex(1, 1, 0, 0, 1, 0, 0, 1), ex(1, 1, 0, 0, 0, 0, 0, 1)};
    for (int i = 0; i < 5; i++) begin
      step(stim[i]);
      vectors++;
      if (obs() !== exp[i]) begin
        miscompares++;
        $display("FAIL handover[%0d]: got %h expected %h", i, obs(), exp[i]);
      end
    end
  endtask

  task automatic test_wrong_player();
    logic [4:0] stim [3];
    stim = '{B2, F2, B2 | F2};
    for (int i = 0; i < 3; i++) begin
      step(stim[i]);
      vectors++;
      if (obs() !== ex(1, 1, 0, 0, 0, 0, 0, 1)) begin
        miscompares++;
        $display("FAIL wrong_player[%0d]: got %h expected %h", i, obs(), ex(1, 1, 0, 0, 0, 0, 0, 1));
      end
    end
  endtask

  task automatic test_pause_resume();
    logic [4:0] stim [9];
    vec_t       exp  [9];
    stim = '{B1, SP | B2, B1, B2, F2, SP, B2, SP, SP};
    exp  = '{ex(2, 0, 1, 1, 0, 0, 0, 1), ex(3, 0, 0, 0, 0, 0, 0, 1), ex(3, 0, 0, 0, 0, 0, 0, 1),
             ex(3, 0, 0, 0, 0, 0, 0, 1), ex(3, 0, 0, 0, 0, 0, 0, 1), ex(2, 0, 1, 0, 0, 0, 0, 1),
             ex(1, 1, 0, 0, 1, 0, 0, 2), ex(3, 0, 0, 0, 0, 0, 0, 2), ex(1, 1, 0, 0, 0, 0, 0, 2)};
    for (int i = 0; i < 9; i++) begin
      step(stim[i]);
      vectors++;
      if (obs() !== exp[i]) begin
        miscompares++;
        $display("FAIL pause_resume[%0d]: got %h expected %h", i, obs(), exp[i]);
      end
    end
  endtask

  task automatic test_flag_p1();
    logic [4:0] stim [5];
    stim = '{F1 | B1 | SP, SP, B1, B2, F2};
    for (int i = 0; i < 5; i++) begin
      step(stim[i]);
      vectors++;
      if (obs() !== ex(4, 0, 0, 0, 0, 1, 0, 2)) begin
        miscompares++;
        $display("FAIL flag_p1[%0d]: got %h expected %h", i, obs(), ex(4, 0, 0, 0, 0, 1, 0, 2));
      end
    end
  endtask

  task automatic test_flag_p2_resume();
    logic [4:0] stim [6];
    vec_t       exp  [6];
    pulse_clr();
    stim = '{SP, B1, SP, F2 | SP, F2 | SP | B2, SP | B1};
    exp  = '{ex(1, 1, 0, 0, 0, 0, 0, 0), ex(2, 0, 1, 1, 0, 0, 0, 0), ex(3, 0, 0, 0, 0, 0, 0, 0),
             ex(2, 0, 1, 0, 0, 0, 0, 0), ex(4, 0, 0, 0, 0, 1, 1, 0), ex(4, 0, 0, 0, 0, 1, 1, 0)};
    for (int i = 0; i < 6; i++) begin
      step(stim[i]);
      vectors++;
      if (obs() !== exp[i]) begin
        miscompares++;
        $display("FAIL flag_p2_resume[%0d]: got %h expected %h", i, obs(), exp[i]);
      end
    end
  endtask

  task automatic test_saturation();
    pulse_clr();
    step(SP);
    for (int k = 1; k <= 5; k++) begin
      step(B1);
      step(B2);
      vectors++;
      if (obs() !== ex(1, 1, 0, 0, 1, 0, 0, k)) begin
        miscompares++;
        $display("FAIL moves_wide[%0d]: got %h expected %h", k, obs(), ex(1, 1, 0, 0, 1, 0, 0, k));
      end
      vectors++;
      if (s_moves !== ((k > 3) ? 2'd3 : 2'(k))) begin
        miscompares++;
        $display("FAIL moves_sat[%0d]: got %0d expected %0d", k, s_moves, (k > 3) ? 3 : k);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] stim [6];
    pulse_clr();
    stim = '{SP, B1, B2, B1, B2, B1};
    for (int i = 0; i < 6; i++) step(stim[i]);
    vectors++;
    if (obs() !== ex(2, 0, 1, 1, 0, 0, 0, 2)) begin
      miscompares++;
      $display("FAIL async_setup: got %h expected %h", obs(), ex(2, 0, 1, 1, 0, 0, 0, 2));
    end
    @(posedge CLK);
    #3;
    CLR = 1'b1;
    #1;
    vectors++;
    if (obs() !== ex(0, 0, 0, 0, 0, 0, 0, 0) || s_moves !== 2'd0) begin
      miscompares++;
      $display("FAIL async_clr: got %h expected %h", obs(), ex(0, 0, 0, 0, 0, 0, 0, 0));
    end
    #20;
    CLR = 1'b0;
    step(SP);
    vectors++;
    if (obs() !== ex(1, 1, 0, 0, 0, 0, 0, 0)) begin
      miscompares++;
      $display("FAIL after_clr: got %h expected %h", obs(), ex(1, 1, 0, 0, 0, 0, 0, 0));
    end
  endtask

  initial begin
    test_reset();
    test_handover();
    test_wrong_player();
    test_pause_resume();
    test_flag_p1();
    test_flag_p2_resume();
    test_saturation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
